// File: rtl/motion_pkg.sv
// Shared encodings for the line-follower PI sequencer and its ALU: operand
// selects, ALU gain constants, sequencer states and the per-conversion tables.
package motion_pkg;

  localparam logic [2:0] SRC1_ACCUM     = 3'd0;
  localparam logic [2:0] SRC1_ITERM     = 3'd1;
  localparam logic [2:0] SRC1_ERR       = 3'd2;
  localparam logic [2:0] SRC1_ERR_DIV16 = 3'd3;
  localparam logic [2:0] SRC1_FWD       = 3'd4;

  localparam logic [2:0] SRC0_A2D    = 3'd0;
  localparam logic [2:0] SRC0_INTGRL = 3'd1;
  localparam logic [2:0] SRC0_ICOMP  = 3'd2;
  localparam logic [2:0] SRC0_PCOMP  = 3'd3;
  localparam logic [2:0] SRC0_PTERM  = 3'd4;
  // Any encoding the ALU does not decode feeds a zero operand.
  localparam logic [2:0] SRC0_ZERO   = 3'd7;

  localparam logic [13:0] PTERM = 14'h3680;
  localparam logic [11:0] ITERM = 12'h500;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CONV,
    S_WAIT,
    S_ACC,
    S_ERR,
    S_INTG,
    S_ICOMP,
    S_PCOMP,
    S_RHT1,
    S_RHT2,
    S_LFT1,
    S_LFT2,
    S_DONE
  } state_t;

  // Conversion order, element 0 first.
  localparam logic [5:0][2:0] CH_TBL = {3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1};

  // Weight codes are {mult4, mult2}, so the two can never both be set.
  localparam logic [1:0] W_X1 = 2'b00;
  localparam logic [1:0] W_X2 = 2'b01;
  localparam logic [1:0] W_X4 = 2'b10;
  localparam logic [5:0][1:0] WT_TBL = {W_X4, W_X4, W_X2, W_X2, W_X1, W_X1};

  localparam logic [2:0] LAST_IDX = 3'd5;

endpackage

// File: rtl/mc_seq_fsm.sv
// Control-cycle sequencer: walks the six conversions and the PI arithmetic,
// driving ALU selects/mode lines and one write enable per operand register.
module mc_seq_fsm
  import motion_pkg::*;
#(
  parameter int MULT_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       cnv_cmplt,
  output logic       strt_cnv,
  output logic [2:0] chnnl,
  output logic [2:0] src1sel,
  output logic [2:0] src0sel,
  output logic       multiply,
  output logic       mult2,
  output logic       mult4,
  output logic       sub,
  output logic       saturate,
  output logic       cyc_done,
  output logic       clr,
  output logic       start,
  output logic       accum_we,
  output logic       error_we,
  output logic       intgrl_we,
  output logic       icomp_we,
  output logic       pcomp_we,
  output logic       rht_we,
  output logic       lft_we
);

  localparam int HOLD_W = (MULT_CYC > 1) ? $clog2(MULT_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MULT_CYC - 1);

  state_t            state, nxt_state;
  logic [2:0]        idx, nxt_idx;
  logic [HOLD_W-1:0] hold, nxt_hold;
  logic [1:0]        int_dec, nxt_int_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      hold    <= '0;
      int_dec <= '0;
    end else begin
      state   <= nxt_state;
      idx     <= nxt_idx;
      hold    <= nxt_hold;
      int_dec <= nxt_int_dec;
    end
  end

  always_comb begin
    nxt_state   = state;
    nxt_idx     = idx;
    nxt_hold    = hold;
    nxt_int_dec = int_dec;
    strt_cnv    = 1'b0;
    chnnl       = 3'd0;
    src1sel     = SRC1_ACCUM;
    src0sel     = SRC0_A2D;
    multiply    = 1'b0;
    mult2       = 1'b0;
    mult4       = 1'b0;
    sub         = 1'b0;
    saturate    = 1'b0;
    cyc_done    = 1'b0;
    clr         = 1'b0;
    start       = 1'b0;
    accum_we    = 1'b0;
    error_we    = 1'b0;
    intgrl_we   = 1'b0;
    icomp_we    = 1'b0;
    pcomp_we    = 1'b0;
    rht_we      = 1'b0;
    lft_we      = 1'b0;

    // Dropping go abandons the cycle from any state; a late cnv_cmplt then
    // lands in IDLE where it has no effect.
    if (!go) begin
      nxt_state   = S_IDLE;
      nxt_idx     = '0;
      nxt_hold    = '0;
      nxt_int_dec = '0;
      clr         = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          start     = 1'b1;
          nxt_idx   = '0;
          nxt_state = S_CONV;
        end
        S_CONV: begin
          strt_cnv  = 1'b1;
          chnnl     = CH_TBL[idx];
          nxt_state = S_WAIT;
        end
        S_WAIT: begin
          chnnl = CH_TBL[idx];
          if (cnv_cmplt) nxt_state = S_ACC;
        end
        S_ACC: begin
          src1sel        = SRC1_ACCUM;
          src0sel        = SRC0_A2D;
          {mult4, mult2} = WT_TBL[idx];
          sub            = idx[0];
          accum_we       = 1'b1;
          if (idx == LAST_IDX) begin
            nxt_state = S_ERR;
          end else begin
            nxt_idx   = idx + 3'd1;
            nxt_state = S_CONV;
          end
        end
        S_ERR: begin
          src1sel   = SRC1_ACCUM;
          src0sel   = SRC0_ZERO;
          saturate  = 1'b1;
          error_we  = 1'b1;
          nxt_state = S_INTG;
        end
        S_INTG: begin
          src1sel   = SRC1_ERR_DIV16;
          src0sel   = SRC0_INTGRL;
          saturate  = 1'b1;
          intgrl_we = (int_dec == 2'd3);
          nxt_state = S_ICOMP;
        end
        S_ICOMP: begin
          src1sel  = SRC1_ITERM;
          src0sel  = SRC0_INTGRL;
          multiply = 1'b1;
          if (hold == HOLD_LAST) begin
            icomp_we  = 1'b1;
            nxt_hold  = '0;
            nxt_state = S_PCOMP;
          end else begin
            nxt_hold = hold + 1'b1;
          end
        end
        S_PCOMP: begin
          src1sel  = SRC1_ERR;
          src0sel  = SRC0_PTERM;
          multiply = 1'b1;
          if (hold == HOLD_LAST) begin
            pcomp_we  = 1'b1;
            nxt_hold  = '0;
            nxt_state = S_RHT1;
          end else begin
            nxt_hold = hold + 1'b1;
          end
        end
        S_RHT1: begin
          src1sel   = SRC1_FWD;
          src0sel   = SRC0_PCOMP;
          sub       = 1'b1;
          accum_we  = 1'b1;
          nxt_state = S_RHT2;
        end
        S_RHT2: begin
          src1sel   = SRC1_ACCUM;
          src0sel   = SRC0_ICOMP;
          sub       = 1'b1;
          saturate  = 1'b1;
          rht_we    = 1'b1;
          nxt_state = S_LFT1;
        end
        S_LFT1: begin
          src1sel   = SRC1_FWD;
          src0sel   = SRC0_PCOMP;
          accum_we  = 1'b1;
          nxt_state = S_LFT2;
        end
        S_LFT2: begin
          src1sel   = SRC1_ACCUM;
          src0sel   = SRC0_ICOMP;
          saturate  = 1'b1;
          lft_we    = 1'b1;
          nxt_state = S_DONE;
        end
        S_DONE: begin
          cyc_done    = 1'b1;
          nxt_int_dec = int_dec + 2'd1;
          nxt_state   = S_IDLE;
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/motion_cntrl.sv
// Line-follower motion controller: owns the ALU operand registers and loads
// them from the ALU result as the sequencer steps through a control cycle.
module motion_cntrl
  import motion_pkg::*;
#(
  parameter logic [11:0] FWD_MAX  = 12'h6FF,
  parameter int          MULT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2d_res,
  input  logic [15:0] dst,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [2:0]  src1sel,
  output logic [2:0]  src0sel,
  output logic        multiply,
  output logic        mult2,
  output logic        mult4,
  output logic        sub,
  output logic        saturate,
  output logic [15:0] Accum,
  output logic [15:0] Pcomp,
  output logic [11:0] Error,
  output logic [11:0] Intgrl,
  output logic [11:0] Icomp,
  output logic [11:0] Fwd,
  output logic [11:0] lft,
  output logic [11:0] rht,
  output logic        cyc_done
);

  logic clr, start;
  logic accum_we, error_we, intgrl_we, icomp_we, pcomp_we, rht_we, lft_we;

  // The A2D result reaches the accumulator through the ALU, not directly.
  logic unused_a2d;
  assign unused_a2d = ^A2d_res;

  function automatic logic [11:0] fwd_ramp(input logic [11:0] cur);
    if (cur >= FWD_MAX) return FWD_MAX;
    return cur + 12'd1;
  endfunction

  mc_seq_fsm #(
    .MULT_CYC(MULT_CYC)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .cnv_cmplt(cnv_cmplt),
    .strt_cnv (strt_cnv),
    .chnnl    (chnnl),
    .src1sel  (src1sel),
    .src0sel  (src0sel),
    .multiply (multiply),
    .mult2    (mult2),
    .mult4    (mult4),
    .sub      (sub),
    .saturate (saturate),
    .cyc_done (cyc_done),
    .clr      (clr),
    .start    (start),
    .accum_we (accum_we),
    .error_we (error_we),
    .intgrl_we(intgrl_we),
    .icomp_we (icomp_we),
    .pcomp_we (pcomp_we),
    .rht_we   (rht_we),
    .lft_we   (lft_we)
  );

  // Error survives an abort; everything else restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      Accum  <= '0;
      Pcomp  <= '0;
      Error  <= '0;
      Intgrl <= '0;
      Icomp  <= '0;
      Fwd    <= '0;
      lft    <= '0;
      rht    <= '0;
    end else if (clr) begin
      Accum  <= '0;
      Pcomp  <= '0;
      Intgrl <= '0;
      Icomp  <= '0;
      Fwd    <= '0;
      lft    <= '0;
      rht    <= '0;
    end else begin
      if (start) begin
        Accum <= '0;
        Fwd   <= fwd_ramp(Fwd);
      end
      if (accum_we)  Accum  <= dst;
      if (error_we)  Error  <= dst[11:0];
      if (intgrl_we) Intgrl <= dst[11:0];
      if (icomp_we)  Icomp  <= dst[11:0];
      if (pcomp_we)  Pcomp  <= dst;
      if (rht_we)    rht    <= dst[11:0];
      if (lft_we)    lft    <= dst[11:0];
    end
  end

endmodule
